// File: rtl/alu_sched_pkg.sv
// Shared definitions for the two-requester ALU operation scheduler.
// State encoding, requester ids and default datapath widths.
package alu_sched_pkg;

    localparam int unsigned DefWidth = 16;
    localparam int unsigned DefFunW  = 4;

    localparam logic ReqId0 = 1'b0;
    localparam logic ReqId1 = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StWait  = 2'b10,
        StResp  = 2'b11
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time is granted.
// The last-grant record only moves when the scheduler accepts the granted command.
module rr_arbiter2
    import alu_sched_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic accept_i,
    output logic grant_id_o,
    output logic grant_valid_o
);

    logic last_q;

    always_comb begin
        grant_valid_o = valid0_i | valid1_i;
        if (valid0_i && valid1_i) begin
            grant_id_o = ~last_q;
        end else if (valid1_i) begin
            grant_id_o = ReqId1;
        end else begin
            grant_id_o = ReqId0;
        end
    end

    // Reset to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= ReqId1;
        end else if (accept_i) begin
            last_q <= grant_id_o;
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one registered ALU between two requesters: arbitrate, issue a one-cycle enable,
// wait for the result flag (bounded by a timeout) and return the result on a valid/ready channel.
module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned FUN_W   = DefFunW,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic [FUN_W-1:0] req0_fun_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    input  logic [FUN_W-1:0] req1_fun_i,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [FUN_W-1:0] alu_fun_o,
    output logic             alu_enable_o,
    input  logic [WIDTH-1:0] alu_out_i,
    input  logic             alu_flag_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_err_o,
    output logic             busy_o
);

    localparam int unsigned    CntW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_b_q, rsp_data_q;
    logic [FUN_W-1:0] alu_fun_q;
    logic            rsp_id_q, rsp_err_q;
    logic            grant_id, grant_valid, accept;
    logic            capture_flag, capture_timeout;

    // Readys are gated by reset so nothing is offered while reset is held.
    assign accept = (state_q == StIdle) && grant_valid && !rst_i;

    rr_arbiter2 u_arb (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .valid0_i      (req0_valid_i),
        .valid1_i      (req1_valid_i),
        .accept_i      (accept),
        .grant_id_o    (grant_id),
        .grant_valid_o (grant_valid)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        capture_flag    = 1'b0;
        capture_timeout = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StIssue;
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (alu_flag_i) begin
                    capture_flag = 1'b1;
                    state_d      = StResp;
                end else if (cnt_q == CntLast) begin
                    capture_timeout = 1'b1;
                    state_d         = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        alu_enable_o = (state_q == StIssue);
        rsp_valid_o  = (state_q == StResp);
        busy_o       = (state_q != StIdle);
        req0_ready_o = accept && (grant_id == ReqId0);
        req1_ready_o = accept && (grant_id == ReqId1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_fun_q  <= '0;
            rsp_id_q   <= ReqId0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                alu_a_q   <= (grant_id == ReqId1) ? req1_a_i : req0_a_i;
                alu_b_q   <= (grant_id == ReqId1) ? req1_b_i : req0_b_i;
                alu_fun_q <= (grant_id == ReqId1) ? req1_fun_i : req0_fun_i;
                rsp_id_q  <= grant_id;
            end
            if (capture_flag) begin
                rsp_data_q <= alu_out_i;
                rsp_err_q  <= 1'b0;
            end else if (capture_timeout) begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b1;
            end
        end
    end

    assign alu_a_o    = alu_a_q;
    assign alu_b_o    = alu_b_q;
    assign alu_fun_o  = alu_fun_q;
    assign rsp_id_o   = rsp_id_q;
    assign rsp_data_o = rsp_data_q;
    assign rsp_err_o  = rsp_err_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Scoreboard bench for alu_op_scheduler: random commands, a behavioural ALU with chosen flag
// latency, and a monitor that checks every response against the queued expectation.
module tb_alu_op_scheduler;

    localparam int W  = 16;
    localparam int FW = 4;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req0_valid_i, req1_valid_i, req0_ready_o, req1_ready_o;
    logic [W-1:0]  req0_a_i, req0_b_i, req1_a_i, req1_b_i;
    logic [FW-1:0] req0_fun_i, req1_fun_i;
    logic [W-1:0]  alu_a_o, alu_b_o, alu_out_i, rsp_data_o;
    logic [FW-1:0] alu_fun_o;
    logic          alu_enable_o, alu_flag_i, rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_err_o, busy_o;

    alu_op_scheduler #(.WIDTH(W), .FUN_W(FW), .TIMEOUT(TO)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_a_i     (req0_a_i),
        .req0_b_i     (req0_b_i),
        .req0_fun_i   (req0_fun_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_a_i     (req1_a_i),
        .req1_b_i     (req1_b_i),
        .req1_fun_i   (req1_fun_i),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_fun_o    (alu_fun_o),
        .alu_enable_o (alu_enable_o),
        .alu_out_i    (alu_out_i),
        .alu_flag_i   (alu_flag_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic         id;
        logic [W-1:0] data;
        logic         err;
        int           acc_cyc;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   lat_q[$];
    int   n_tests = 0, n_fail = 0;
    int   acc_cnt = 0, rsp_cnt = 0, rsp_seen = 0, acc_cyc_last = 0;
    logic m_last = 1'b1;

    // Pending command per requester; lat = cycle of WAIT in which the flag rises (0 = never).
    bit            has [2];
    logic [W-1:0]  ca [2];
    logic [W-1:0]  cb [2];
    logic [FW-1:0] cf [2];
    int            cl [2];

    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [FW-1:0] f);
        case (f)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a ^ b;
            4'd3:    return ~(a | b);
            4'd4:    return a + b;
            4'd5:    return a - b;
            4'd6:    return a;
            4'd7:    return ~a;
            default: return b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_alu_enable"}, alu_enable_o, 0);
        chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_readys"}, {req1_ready_o, req0_ready_o}, 0);
        chk({tag, "_alu_ops"}, {alu_a_o, alu_b_o}, 0);
        chk({tag, "_alu_fun"}, alu_fun_o, 0);
        chk({tag, "_rsp_fields"}, {rsp_id_o, rsp_err_o, rsp_data_o}, 0);
    endtask

    task automatic set_cmd(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [FW-1:0] f, input int lat);
        has[n] = 1'b1; ca[n] = a; cb[n] = b; cf[n] = f; cl[n] = lat;
    endtask

    task automatic new_cmd(input int n);
        int l;
        if ($urandom_range(0, 9) < 7) l = $urandom_range(1, TO);
        else l = (($urandom_range(0, 2) == 0) ? 0 : $urandom_range(TO + 1, TO + 2));
        set_cmd(n, W'($urandom), W'($urandom), FW'($urandom_range(0, 15)), l);
    endtask

    // One cycle: drive at the falling edge, then check readys/busy/enable against the model.
    // rr_mode: 0 hold rsp_ready low, 1 hold high, 2 random.
    task automatic step(input int rr_mode, input bit gen);
        bit         idle;
        logic       g;
        logic [1:0] exp_rdy;
        exp_t       it;
        @(negedge clk_i);
        if (gen) for (int n = 0; n < 2; n++) if (!has[n] && $urandom_range(0, 9) < 7) new_cmd(n);
        req0_valid_i = has[0]; req0_a_i = ca[0]; req0_b_i = cb[0]; req0_fun_i = cf[0];
        req1_valid_i = has[1]; req1_a_i = ca[1]; req1_b_i = cb[1]; req1_fun_i = cf[1];
        rsp_ready_i  = (rr_mode == 1) || (rr_mode == 2 && $urandom_range(0, 9) < 6);
        #2;
        idle    = (acc_cnt == rsp_seen);
        g       = (has[0] && has[1]) ? ~m_last : has[1];
        exp_rdy = 2'b00;
        if (idle && has[0] && !g) exp_rdy[0] = 1'b1;
        if (idle && has[1] && g)  exp_rdy[1] = 1'b1;
        chk("req_ready", {req1_ready_o, req0_ready_o}, exp_rdy);
        chk("busy", busy_o, !idle);
        chk("alu_enable", alu_enable_o, (!idle && cyc == acc_cyc_last));
        if (!idle && (cyc - acc_cyc_last) > 40) begin
            n_tests++; n_fail++;
            $display("FAIL rsp_watchdog: no response %0d cycles after accept, expected one", cyc - acc_cyc_last);
            acc_cyc_last = cyc;
        end
        if (exp_rdy != 2'b00) begin
            it.id      = g;
            it.err     = (cl[g] == 0) || (cl[g] > TO);
            it.data    = it.err ? '0 : alu_ref(ca[g], cb[g], cf[g]);
            it.acc_cyc = cyc + 1;
            it.lat     = it.err ? (1 + TO) : (1 + cl[g]);
            sb.push_back(it);
            lat_q.push_back(cl[g]);
            has[g]       = 1'b0;
            m_last       = g;
            acc_cnt++;
            acc_cyc_last = cyc + 1;
        end
        rsp_seen = rsp_cnt;
    endtask

    task automatic drain();
        int k = 0;
        while ((has[0] || has[1] || acc_cnt != rsp_cnt) && k < 200) begin
            step(1, 1'b0);
            k++;
        end
        if (k >= 200) begin
            n_tests++; n_fail++;
            $display("FAIL drain: %0d responses outstanding after 200 cycles, expected 0", acc_cnt - rsp_cnt);
        end
    endtask

    // Behavioural ALU: raises the flag in the requested WAIT cycle with the result of its inputs.
    initial begin
        int cd = 0;
        alu_flag_i = 1'b0;
        alu_out_i  = '0;
        forever begin
            @(negedge clk_i);
            #1;
            alu_flag_i = 1'b0;
            alu_out_i  = W'($urandom);
            if (rst_i) begin
                cd = 0;
                continue;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    alu_flag_i = 1'b1;
                    alu_out_i  = alu_ref(alu_a_o, alu_b_o, alu_fun_o);
                end
            end
            if (alu_enable_o && lat_q.size() > 0) cd = lat_q.pop_front();
        end
    end

    // Response monitor.
    initial begin
        bit   first = 1'b1;
        exp_t it;
        forever begin
            @(negedge clk_i);
            #1;
            if (rst_i) begin
                first = 1'b1;
                continue;
            end
            if (rsp_valid_o) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rsp_unexpected: rsp_valid=1 id=%0d data=%0h, expected no response", rsp_id_o, rsp_data_o);
                end else begin
                    it = sb[0];
                    chk("rsp_id", rsp_id_o, it.id);
                    chk("rsp_data", rsp_data_o, it.data);
                    chk("rsp_err", rsp_err_o, it.err);
                    if (first) chk("rsp_latency", cyc - it.acc_cyc, it.lat);
                    first = 1'b0;
                    if (rsp_ready_i) begin
                        void'(sb.pop_front());
                        rsp_cnt++;
                        first = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int k;
        has[0] = 0; has[1] = 0;
        ca[0] = '0; cb[0] = '0; cf[0] = '0; cl[0] = 1;
        ca[1] = '0; cb[1] = '0; cf[1] = '0; cl[1] = 1;
        rst_i = 1'b1;
        req0_valid_i = 1'b1; req1_valid_i = 1'b1; rsp_ready_i = 1'b0;
        req0_a_i = '1; req0_b_i = '1; req0_fun_i = '1;
        req1_a_i = '1; req1_b_i = '1; req1_fun_i = '1;
        #3;
        chk_outputs_zero("reset");
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        @(negedge clk_i);
        #3 rst_i = 1'b0;

        // AND on requester 0 with the response held off for several cycles.
        set_cmd(0, 16'hF0F0, 16'h0FF0, 4'b0000, 1);
        repeat (9) step(0, 1'b0);
        drain();

        // Reset while waiting on a flag that never comes.
        set_cmd(0, W'($urandom), W'($urandom), 4'd4, 0);
        k = acc_cnt;
        step(1, 1'b0);
        chk("reset_test_accept", acc_cnt, k + 1);
        step(1, 1'b0);
        step(1, 1'b0);
        chk("busy_before_reset", busy_o, 1);
        #1 rst_i = 1'b1;
        #1;
        chk_outputs_zero("mid_reset");
        sb.delete(); lat_q.delete();
        acc_cnt = 0; rsp_cnt = 0; rsp_seen = 0; m_last = 1'b1;
        has[0] = 0; has[1] = 0;
        @(negedge clk_i);
        #3 rst_i = 1'b0;

        // Tie straight after reset goes to requester 0, then NOR on requester 1.
        set_cmd(0, W'($urandom), W'($urandom), 4'd2, 2);
        set_cmd(1, W'($urandom), W'($urandom), 4'd1, 3);
        drain();
        set_cmd(1, 16'h0000, 16'h0000, 4'b0011, 1);
        drain();

        // Both requesters always valid, always-ready response.
        for (int i = 0; i < 8; i++) begin
            if (!has[0]) new_cmd(0);
            if (!has[1]) new_cmd(1);
            step(1, 1'b0);
        end
        drain();

        repeat (800) step(2, 1'b1);
        drain();
        repeat (3) step(1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
